// File: rtl/fwl_pkg.sv
// Flowing water lights: shared rate encodings and default divisors.
// Divisor defaults assume a 100 MHz system clock.
package fwl_pkg;

    typedef enum logic [1:0] {
        FREQ_100HZ = 2'b00,
        FREQ_10HZ  = 2'b01,
        FREQ_4HZ   = 2'b10,
        FREQ_1HZ   = 2'b11
    } freq_e;

    localparam int CNT_W = 27;

    localparam int DEF_DIV_100HZ = 1_000_000;
    localparam int DEF_DIV_10HZ  = 10_000_000;
    localparam int DEF_DIV_4HZ   = 25_000_000;
    localparam int DEF_DIV_1HZ   = 100_000_000;

    localparam logic [7:0] LED_RESET = 8'h01;

endpackage

// File: rtl/fwl_rate_div.sv
// Step-rate divider: one-cycle clk_en every N running cycles,
// restarting whenever the selected rate changes.
module fwl_rate_div
    import fwl_pkg::*;
#(
    parameter int DIV_100HZ = DEF_DIV_100HZ,
    parameter int DIV_10HZ  = DEF_DIV_10HZ,
    parameter int DIV_4HZ   = DEF_DIV_4HZ,
    parameter int DIV_1HZ   = DEF_DIV_1HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] freq_set,
    output logic       clk_en
);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_freq_q;
    logic [CNT_W-1:0] w_last;
    logic             w_changed;
    logic             w_wrap;
    freq_e            w_freq;

    assign w_freq = freq_e'(freq_set);

    always_comb begin
        w_last = CNT_W'(DIV_100HZ - 1);
        unique case (w_freq)
            FREQ_100HZ: w_last = CNT_W'(DIV_100HZ - 1);
            FREQ_10HZ:  w_last = CNT_W'(DIV_10HZ - 1);
            FREQ_4HZ:   w_last = CNT_W'(DIV_4HZ - 1);
            FREQ_1HZ:   w_last = CNT_W'(DIV_1HZ - 1);
        endcase
    end

    assign w_changed = (freq_set != r_freq_q);
    // >= rather than == so a count stranded above a new limit still wraps
    assign w_wrap    = (r_cnt >= w_last);
    assign clk_en    = enable & ~w_changed & w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_freq_q <= '0;
        end else begin
            r_freq_q <= freq_set;
            if (!enable || w_changed || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/flowing_water_lights.sv
// Flowing water lights: button start/pause, one-hot LED rotation
// at a selectable rate and direction.
module flowing_water_lights
    import fwl_pkg::*;
#(
    parameter int DIV_100HZ = DEF_DIV_100HZ,
    parameter int DIV_10HZ  = DEF_DIV_10HZ,
    parameter int DIV_4HZ   = DEF_DIV_4HZ,
    parameter int DIV_1HZ   = DEF_DIV_1HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [1:0] freq_set,
    input  logic       dir_set,
    output logic [7:0] led
);

    logic r_sync1;
    logic r_sync2;
    logic r_btn_q;
    logic pos_edge_button;
    logic running;
    logic clk_en;

    assign pos_edge_button = r_sync2 & ~r_btn_q;

    fwl_rate_div #(
        .DIV_100HZ (DIV_100HZ),
        .DIV_10HZ  (DIV_10HZ),
        .DIV_4HZ   (DIV_4HZ),
        .DIV_1HZ   (DIV_1HZ)
    ) u_rate_div (
        .clk      (clk),
        .rst      (rst),
        .enable   (running),
        .freq_set (freq_set),
        .clk_en   (clk_en)
    );

    // A button edge wins over a coincident step: toggle only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_btn_q <= 1'b0;
            running <= 1'b0;
            led     <= LED_RESET;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_btn_q <= r_sync2;
            if (pos_edge_button) begin
                running <= ~running;
            end else if (clk_en && running) begin
                led <= dir_set ? {led[6:0], led[7]}
                               : {led[0], led[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_flowing_water_lights.sv
// Scoreboard bench: a timestamp-based model predicts LED steps,
// a monitor compares each DUT LED change against the queue.
`timescale 1ns/1ps
module tb_flowing_water_lights;

    localparam int D0 = 1000;
    localparam int D1 = 10000;
    localparam int D2 = 25000;
    localparam int D3 = 100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       dir_set = 1'b0;
    logic [1:0] freq_set = 2'b00;
    logic [7:0] led;

    always #5 clk = ~clk;

    flowing_water_lights #(
        .DIV_100HZ (D0),
        .DIV_10HZ  (D1),
        .DIV_4HZ   (D2),
        .DIV_1HZ   (D3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .freq_set (freq_set),
        .dir_set  (dir_set),
        .led      (led)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] led;
    } exp_t;

    exp_t q[$];

    // Reference model: lit LED index, run flag, and the edge number
    // at which the current step interval began.
    bit         m_run = 1'b0;
    int         m_idx = 0;
    int         m_anchor = 0;
    logic [1:0] m_prev_f = 2'b00;
    bit   [2:0] hist = 3'b000;
    int         m_en_cnt = 0;
    int         m_pe_cnt = 0;

    int         mk;
    int         mn;
    bit         mpe;
    bit         men;
    bit         mfchg;

    function automatic logic [7:0] pat(input int i);
        logic [7:0] one;
        one = 8'h01;
        return one << i;
    endfunction

    function automatic int div_of(input logic [1:0] f);
        case (f)
            2'b00:   return D0;
            2'b01:   return D1;
            2'b10:   return D2;
            default: return D3;
        endcase
    endfunction

    // Runs before edge mk: predicts what that edge does.
    // A button level sampled at edge x becomes a toggle at edge x+2.
    always @(negedge clk) begin
        mk    = cyc + 1;
        mn    = div_of(freq_set);
        mfchg = (freq_set != m_prev_f);
        mpe   = hist[1] && !hist[2];
        men   = m_run && !mfchg && ((mk - m_anchor) % mn == 0);
        if (mpe) m_pe_cnt++;
        if (men) m_en_cnt++;
        if (rst) begin
            m_run = 1'b0;
            if (m_idx != 0) begin
                m_idx = 0;
                q.push_back('{mk, pat(0)});
            end
            hist     = 3'b000;
            m_prev_f = 2'b00;
        end else begin
            if (mpe) begin
                m_run    = !m_run;
                m_anchor = mk;
            end else begin
                if (men) begin
                    m_idx = dir_set ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
                    q.push_back('{mk, pat(m_idx)});
                end
                if (m_run && mfchg) m_anchor = mk;
            end
            hist     = {hist[1:0], button};
            m_prev_f = freq_set;
        end
    end

    int en_seen = 0;
    int pe_seen = 0;

    initial begin : monitor
        logic [7:0] prev;
        exp_t       e;
        prev = 8'h01;
        forever begin
            @(posedge clk);
            #1;
            if (dut.clk_en === 1'b1) en_seen++;
            if (dut.pos_edge_button === 1'b1) pe_seen++;
            if (cyc >= 2) begin
                chk("running", 32'(dut.running), 32'(m_run));
                chk("onehot", $countones(led), 1);
                if (led !== prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_step", 32'(led), 32'(prev));
                    end else begin
                        e = q.pop_front();
                        chk("step_led", 32'(led), 32'(e.led));
                        chk("step_cycle", cyc, e.cyc);
                    end
                    prev = led;
                end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    chk("missed_step", 32'(led), 32'(e.led));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic press();
        button = 1'b1;
        cycles(1);
        button = 1'b0;
    endtask

    task automatic hit_step();
        int  i;
        bit  found;
        found = 1'b0;
        for (i = 0; i < 2 * D0 && !found; i++) begin
            if ((cyc + 3 - m_anchor) % D0 == 0) found = 1'b1;
            else cycles(1);
        end
        chk("hit_step_found", 32'(found), 32'd1);
        press();
    endtask

    initial begin : stim
        int pend;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        chk("reset_led", 32'(led), 32'h01);
        chk("reset_running", 32'(dut.running), 32'd0);
        cycles(10000);
        chk("idle_led", 32'(led), 32'h01);

        freq_set = 2'b00;
        dir_set  = 1'b0;
        press();
        cycles(2010);
        chk("right_two_steps", 32'(led), 32'h40);

        dir_set = 1'b1;
        cycles(3000);
        chk("left_wrap", 32'(led), 32'h02);

        freq_set = 2'b01;
        cycles(10005);
        chk("rate_10hz", 32'(led), 32'h04);

        freq_set = 2'b10;
        cycles(25005);
        chk("rate_4hz", 32'(led), 32'h08);

        freq_set = 2'b00;
        press();
        cycles(5000);
        chk("paused_led", 32'(led), 32'h08);
        chk("paused_run", 32'(dut.running), 32'd0);

        press();
        cycles(1005);
        chk("resume_step", 32'(led), 32'h10);

        hit_step();
        cycles(5);
        chk("simul_run", 32'(dut.running), 32'd0);
        chk("simul_led", 32'(led), 32'h10);

        press();
        cycles(1500);
        chk("prerst_led", 32'(led), 32'h20);
        rst    = 1'b1;
        button = 1'b1;
        cycles(2);
        rst    = 1'b0;
        button = 1'b0;
        chk("midrst_led", 32'(led), 32'h01);
        chk("midrst_run", 32'(dut.running), 32'd0);

        press();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: press();
                1: dir_set = 1'($urandom);
                2: begin
                    freq_set = 2'($urandom);
                    cycles($urandom_range(1, 50));
                    freq_set = 2'b00;
                end
                default: ;
            endcase
            cycles($urandom_range(100, 1500));
        end

        freq_set = 2'b00;
        cycles(10);
        chk("clk_en_count", en_seen, m_en_cnt);
        chk("pos_edge_count", pe_seen, m_pe_cnt);
        pend = 0;
        foreach (q[j]) if (q[j].cyc <= cyc) pend++;
        chk("queue_drained", pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
